// File: rtl/ika87ad_mcseq.sv
// Microcode sequencer: owns the uPC, times machine cycles in T-states and issues ROM read ticks.
// Optional bus wait states are compiled in with `define IKA87AD_WAIT_EN.
module ika87ad_mcseq #(
    parameter logic [7:0] IRD_ADDR = 8'hFF
) (
    input  logic        i_CLK,
    input  logic        i_RST_n,
    input  logic        i_CEN,
    input  logic [17:0] i_MCROM_DATA,
    input  logic        i_DEC_VALID,
    input  logic [7:0]  i_DEC_ADDR,
    input  logic        i_WAIT_n,
    output logic        o_MCROM_READ_TICK,
    output logic [7:0]  o_MCROM_ADDR,
    output logic [1:0]  o_CYCLE_TYPE,
    output logic [2:0]  o_TSTATE,
    output logic        o_OPCODE_FETCH,
    output logic        o_MCYCLE_END
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] CODE_IDLE = 2'b00;
    localparam logic [1:0] CODE_RD4  = 2'b10;
    localparam logic [2:0] T_WAIT    = 3'd7;

    state_t      state_q, state_d;
    logic [7:0]  upc_q, upc_d;
    logic [2:0]  tstate_q, tstate_d;

    logic        tick;
    logic [7:0]  addr;
    logic [1:0]  code;
    logic [2:0]  last_t;
    logic [7:0]  next_addr;
    logic        unused_bits;

`ifdef IKA87AD_WAIT_EN
    assign unused_bits = ^i_MCROM_DATA[17:2];
`else
    assign unused_bits = ^{i_WAIT_n, i_MCROM_DATA[17:2]};
`endif

    // The ROM word only changes at a tick, so the live bus code is stable all cycle.
    assign code      = (state_q == ST_BOOT) ? CODE_IDLE : i_MCROM_DATA[1:0];
    assign last_t    = (code == CODE_RD4) ? 3'd4 : 3'd3;
    assign next_addr = (code == CODE_RD4) ? (i_DEC_VALID ? i_DEC_ADDR : IRD_ADDR)
                                          : upc_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        upc_d    = upc_q;
        tstate_d = tstate_q;
        tick     = 1'b0;
        addr     = upc_q;
        case (state_q)
            ST_BOOT: begin
                if (i_CEN) begin
                    tick     = 1'b1;
                    addr     = IRD_ADDR;
                    upc_d    = IRD_ADDR;
                    state_d  = ST_RUN;
                    tstate_d = 3'd1;
                end
            end
            ST_RUN: begin
                if (i_CEN) begin
                    if (tstate_q == last_t) begin
                        tick     = 1'b1;
                        addr     = next_addr;
                        upc_d    = next_addr;
                        tstate_d = 3'd1;
`ifdef IKA87AD_WAIT_EN
                    end else if (tstate_q == 3'd2 && code != CODE_IDLE && !i_WAIT_n) begin
                        state_d  = ST_WAIT;
                        tstate_d = T_WAIT;
`endif
                    end else begin
                        tstate_d = tstate_q + 3'd1;
                    end
                end
            end
            ST_WAIT: begin
`ifdef IKA87AD_WAIT_EN
                if (i_CEN && i_WAIT_n) begin
                    state_d  = ST_RUN;
                    tstate_d = 3'd3;
                end
`else
                state_d  = ST_RUN;
                tstate_d = 3'd3;
`endif
            end
            default: begin
                state_d  = ST_BOOT;
                tstate_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q  <= ST_BOOT;
            upc_q    <= IRD_ADDR;
            tstate_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            upc_q    <= upc_d;
            tstate_q <= tstate_d;
        end
    end

    // Gating with reset drops any tick in flight and forces outputs to zero while held.
    assign o_MCROM_READ_TICK = tick & i_RST_n;
    assign o_MCYCLE_END      = tick & i_RST_n;
    assign o_MCROM_ADDR      = i_RST_n ? addr : 8'h00;
    assign o_CYCLE_TYPE      = code;
    assign o_TSTATE          = tstate_q;
    assign o_OPCODE_FETCH    = (code == CODE_RD4);

endmodule
